// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port 16-bit RAM between two requesters.
//   Master 0 is the CPU fetch/data path, master 1 the loader/debug port.
//   One transaction at a time, round-robin on contention, and a fixed RAM
//   read latency of RAM_LAT cycles (1..7).
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   mN_req/we/addr/wdata      request; fields held stable until mN_ack
//   mN_ack                    one-cycle completion pulse
//   mN_rdata                  read data, valid with mN_ack on a read
//   ram_en/we/addr/wdata      RAM strobe and latched command fields
//   ram_rdata                 RAM read data, valid RAM_LAT cycles after ram_en
//   busy                      high whenever a transaction is in flight
module ram_arbiter #(
  parameter int AW      = 8,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [15:0]   m0_wdata,
  output logic          m0_ack,
  output logic [15:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [15:0]   m1_wdata,
  output logic          m1_ack,
  output logic [15:0]   m1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_wdata,
  input  logic [15:0]   ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_CNT = 3'(RAM_LAT);

  state_t          state, state_nxt;
  logic [2:0]      cnt;
  logic            gnt_id;
  logic            last_gnt;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [15:0]     lat_wdata;
  logic [15:0]     rdata;
  logic            any_req;
  logic            grant_sel;

  assign any_req = m0_req | m1_req;

  // NOTE: every variable driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    // A lone requester wins outright; on a tie the one not served last wins.
    grant_sel = m1_req;
    if (m0_req && m1_req) grant_sel = ~last_gnt;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (cnt == LAT_CNT) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      gnt_id    <= 1'b0;
      last_gnt  <= 1'b1;   // master 0 wins the first tie after reset
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      // Requests are only looked at in IDLE; the in-flight transaction runs
      // entirely from these latched fields.
      if (state == IDLE && any_req) begin
        gnt_id    <= grant_sel;
        last_gnt  <= grant_sel;
        lat_we    <= grant_sel ? m1_we    : m0_we;
        lat_addr  <= grant_sel ? m1_addr  : m0_addr;
        lat_wdata <= grant_sel ? m1_wdata : m0_wdata;
      end

      // Counter is 1 in the first WAIT cycle, so WAIT lasts RAM_LAT cycles.
      if (state == ACCESS) begin
        cnt <= 3'd1;
      end else if (state == WAIT && cnt != LAT_CNT) begin
        cnt <= cnt + 3'd1;
      end

      // Writes leave the shared read-data register untouched.
      if (state == WAIT && cnt == LAT_CNT && !lat_we) begin
        rdata <= ram_rdata;
      end
    end
  end

  assign ram_en    = (state == ACCESS);
  assign ram_we    = (state == ACCESS) && lat_we;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  assign busy      = (state != IDLE);

  assign m0_ack    = (state == RESP) && !gnt_id;
  assign m1_ack    = (state == RESP) &&  gnt_id;
  assign m0_rdata  = rdata;
  assign m1_rdata  = rdata;

endmodule
